sha256_w_stream_reader: RTL and testbench
=========================================

Name: sha256_w_stream_reader

Overview:
- Consumer side of the W-schedule memory interface. Accepts one 512-bit message block, then streams the 64 schedule words W[0..63] in order, one per accepted handshake, to a round/compression stage.
- W[16..63] are generated on the fly from a 16-word sliding window. The expansion uses the same sigma0/sigma1 definitions as the pipeline W-memory stages.
- Sits between the block source (header/digest padder) and the iterative compression core. Supports downstream backpressure.

Parameters:
- NUM_WORDS, 64: schedule words emitted per block; legal range 16..64.
- WORD_W, 32: schedule word width; fixed at 32 (SHA-256).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous assert, active-low (0 = reset).
- blk_valid  input  1  block source has a block on blk_data.
- blk_ready  output  1  reader can accept a block.
- blk_data  input  512  message block; word 0 is blk_data[511:480], word 15 is blk_data[31:0].
- w_valid  output  1  w_data/w_index hold a valid schedule word.
- w_ready  input  1  downstream accepts the word.
- w_data  output  32  schedule word W[t].
- w_index  output  6  t of the current word.
- w_last  output  1  high with the final word (t = NUM_WORDS-1).
- busy  output  1  a block is loaded and not fully streamed.

Behaviour:
- Reset (RST=0, asynchronous):
  - Go to IDLE; window and t counter cleared.
  - Outputs: blk_ready=1, w_valid=0, w_data=0, w_index=0, w_last=0, busy=0.
  - A reset mid-stream aborts the block; no partial words are emitted after release.
- States: IDLE, STREAM.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: capture the 16 words into window[0..15], set t=0, go to STREAM.
  - W[0] is presented on the next cycle. Load-to-first-word latency is 1 cycle.
- STREAM:
  - blk_ready=0; a new block is never accepted while streaming.
  - w_valid=1, w_data=window[0], w_index=t, w_last=(t==NUM_WORDS-1).
  - Registered outputs: w_data, w_index and w_last stay stable while w_valid && !w_ready.
- Advance on w_valid&&w_ready:
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t <= t+1.
- Last word: when the handshake occurs with t==NUM_WORDS-1, go to IDLE. blk_ready returns to 1 on the next cycle, so there are no back-to-back overlapping blocks.
- Throughput: one word per cycle when w_ready is held high. A full block takes 1 + NUM_WORDS cycles from load to IDLE.
- Simultaneous events:
  - blk_valid is ignored in STREAM.
  - w_ready is ignored in IDLE.
  - A w_ready deassert on the last word holds w_last=1 until accepted.
- Counter wrap: t never exceeds NUM_WORDS-1, and the 6-bit counter never wraps.
- Additions are unsigned modulo 2^32; carries are discarded.

Decomposition:
- Package sha256_pkg:
  - word typedef (32-bit);
  - NUM_ROUNDS=64 constant;
  - sigma0 and sigma1 functions;
  - padding constant 32'h80000000.
- Sub-module sha256_w_next: combinational next-word (four 32-bit inputs, one output). It is shared with the pipeline W-memory stages so both compute identical schedules.

Test Plan:
- "abc" block (61626380, 00000000 x14, 00000018), w_ready=1:
  - W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6;
  - w_last only at t=63; blk_ready=1 one cycle after W63.
- Same block with w_ready toggling 1/0 every cycle: identical W sequence; w_data/w_index held stable during each stall; 128 cycles to completion.
- blk_valid held high for the entire run: exactly one block accepted; second capture only after return to IDLE; second stream is correct.
- RST pulsed low at t=30 under load: all outputs at reset values immediately (asynchronous); after release, a new block streams from W0 correctly.
- All-ones block (FFFFFFFF x16): W16 = sigma1(FFFFFFFF)+FFFFFFFF+sigma0(FFFFFFFF)+FFFFFFFF = 003FFFFF+FFFFFFFF+1FFFFFFF+FFFFFFFF = 203FFFFC (mod 2^32); checks carry discard.
- Double-SHA second-block pattern (8 digest words, 80000000, zeros, 00000100): streamed W matches a reference model for all 64 words.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 word type, states, constants and message-schedule sigma functions.
package sha256_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic {IDLE, STREAM} state_e;
   localparam int NUM_ROUNDS = 64;
   localparam word_t PAD_WORD = 32'h8000_0000;
   function automatic word_t sigma0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic word_t sigma1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
endpackage

// File: rtl/sha256_w_next.sv
// sha256_w_next: combinational schedule expansion W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_w_next
   import sha256_pkg::*;
(
   input  word_t w_tm2_i,
   input  word_t w_tm7_i,
   input  word_t w_tm15_i,
   input  word_t w_tm16_i,
   output word_t w_o
);
   assign w_o = sigma1(w_tm2_i) + w_tm7_i + sigma0(w_tm15_i) + w_tm16_i;
endmodule

// File: rtl/sha256_w_stream_reader.sv
// sha256_w_stream_reader: accepts a 512-bit block and streams W[0..NUM_WORDS-1] with valid/ready,
// expanding W[16..] on the fly from a 16-word sliding window.
module sha256_w_stream_reader
   import sha256_pkg::*;
#(
   parameter int NUM_WORDS = 64,
   parameter int WORD_W    = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [511:0]      blk_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WORD_W-1:0] w_data,
   output logic [5:0]        w_index,
   output logic              w_last,
   output logic              busy
);
   localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);
   state_e     state_q, state_d;
   logic [5:0] t_q, t_d;
   word_t      window_q [16];
   word_t      window_d [16];
   word_t      w_nxt;
   sha256_w_next u_next (
      .w_tm2_i (window_q[14]),
      .w_tm7_i (window_q[9]),
      .w_tm15_i(window_q[1]),
      .w_tm16_i(window_q[0]),
      .w_o     (w_nxt)
   );
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      window_d = window_q;
      if (state_q == IDLE) begin
         if (blk_valid) begin
            for (int i = 0; i < 16; i++) window_d[i] = blk_data[511-32*i -: 32];
            t_d     = '0;
            state_d = STREAM;
         end
      end else if (w_ready) begin
         for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
         window_d[15] = w_nxt;
         t_d          = (t_q == LAST) ? '0 : t_q + 6'd1;
         state_d      = (t_q == LAST) ? IDLE : STREAM;
      end
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         t_q     <= '0;
         for (int i = 0; i < 16; i++) window_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         window_q <= window_d;
      end
   end
   // Outputs come straight from registers, so they hold steady through any stall.
   assign busy      = (state_q == STREAM);
   assign blk_ready = !busy;
   assign w_valid   = busy;
   assign w_data    = busy ? window_q[0] : '0;
   assign w_index   = busy ? t_q : '0;
   assign w_last    = busy && (t_q == LAST);
endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// tb_sha256_w_stream_reader: directed self-checking bench for the W-schedule stream reader.
module tb_sha256_w_stream_reader;
   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         w_valid;
   logic         w_ready = 1'b0;
   logic [31:0]  w_data;
   logic [5:0]   w_index;
   logic         w_last;
   logic         busy;
   int           n_cmp = 0;
   int           n_mis = 0;
   logic [31:0]  exp_w [64];
   logic [31:0]  got_w [64];

   localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] ONES = {16{32'hFFFFFFFF}};
   localparam logic [511:0] DSHA = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad,
                                    32'h80000000, {6{32'h0}}, 32'h00000100};

   sha256_w_stream_reader dut (
      .CLK(CLK), .RST(RST), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_index(w_index),
      .w_last(w_last), .busy(busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build(input logic [511:0] d);
      for (int t = 0; t < 16; t++) exp_w[t] = d[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " blk_ready"}, 32'(blk_ready), 32'd1);
      chk({tag, " w_valid"}, 32'(w_valid), 32'd0);
      chk({tag, " w_data"}, w_data, 32'd0);
      chk({tag, " w_index"}, 32'(w_index), 32'd0);
      chk({tag, " w_last"}, 32'(w_last), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge on which W[0] should be visible.
   task automatic load(input logic [511:0] d, input bit hold);
      chk("load blk_ready", 32'(blk_ready), 32'd1);
      blk_data  = d;
      blk_valid = 1'b1;
      @(negedge CLK);
      if (!hold) blk_valid = 1'b0;
   endtask

   // Streams one block against exp_w; returns at the negedge after the last handshake.
   task automatic run_stream(input string tag, input bit tog, input int exp_cycles);
      int k = 0;
      int cyc = 0;
      bit stall = 0;
      logic [31:0] pd = '0;
      logic [5:0] pi = '0;
      while (k < 64 && cyc < 400) begin
         w_ready = tog ? (cyc % 2 == 0) : 1'b1;
         chk({tag, " w_valid"}, 32'(w_valid), 32'd1);
         chk({tag, " w_data"}, w_data, exp_w[k]);
         chk({tag, " w_index"}, 32'(w_index), 32'(k));
         chk({tag, " w_last"}, 32'(w_last), 32'(k == 63));
         chk({tag, " blk_ready"}, 32'(blk_ready), 32'd0);
         if (stall) begin
            chk({tag, " hold data"}, w_data, pd);
            chk({tag, " hold index"}, 32'(w_index), 32'(pi));
         end
         got_w[k] = w_data;
         stall = !w_ready;
         pd = w_data;
         pi = w_index;
         if (w_ready) k++;
         cyc++;
         @(negedge CLK);
      end
      w_ready = 1'b0;
      chk({tag, " words"}, 32'(k), 32'd64);
      chk({tag, " cycles"}, 32'(cyc + 1), 32'(exp_cycles));
      chk({tag, " end blk_ready"}, 32'(blk_ready), 32'd1);
      chk({tag, " end w_valid"}, 32'(w_valid), 32'd0);
      chk({tag, " end busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      @(negedge CLK);
      chk_idle("reset");
      RST = 1'b1;
      @(negedge CLK);
      w_ready = 1'b1;
      @(negedge CLK);
      chk_idle("idle w_ready ignored");
      w_ready = 1'b0;

      build(ABC);
      load(ABC, 0);
      run_stream("abc", 0, 65);
      chk("abc W0", got_w[0], 32'h61626380);
      chk("abc W15", got_w[15], 32'h00000018);
      chk("abc W16", got_w[16], 32'h61626380);
      chk("abc W17", got_w[17], 32'h000F0000);
      chk("abc W18", got_w[18], 32'h7DA86405);
      chk("abc W19", got_w[19], 32'h600003C6);

      load(ABC, 0);
      run_stream("abc toggle", 1, 128);

      load(ABC, 1);
      blk_data = ONES;
      run_stream("hold first", 0, 65);
      build(ONES);
      @(negedge CLK);
      blk_valid = 1'b0;
      run_stream("hold second", 0, 65);
      chk("ones W16", got_w[16], 32'h203FFFFC);

      build(DSHA);
      load(ABC, 0);
      w_ready = 1'b1;
      n = 0;
      while (w_index != 6'd30 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      w_ready = 1'b0;
      chk("mid index", 32'(w_index), 32'd30);
      #2 RST = 1'b0;
      #1 chk_idle("async reset");
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk_idle("after reset");
      load(DSHA, 0);
      run_stream("dsha", 0, 65);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
